// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry / mret return sequencer: drains the pipeline,
// pulses csr_reg trap/return actions and hands the new PC to fetch.
module trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 64,
  parameter bit VECTORED_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        mie_global,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mret_req,
  input  logic        pipe_drained,
  input  logic [31:0] resume_pc,
  input  logic        redirect_ack,
  output logic        flush_req,
  output logic        int_action,
  output logic        ret_action,
  output logic        hw_int,
  output logic [4:0]  int_code,
  output logic [31:0] trap_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mret_done,
  output logic        busy,
  output logic        drain_timeout
);

  localparam int CW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_VAL = CW'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_TAKE, S_RET, S_REDIR} state_t;
  typedef enum logic {K_TRAP, K_RET} kind_t;

  state_t        r_state;
  kind_t         r_kind;
  logic [CW-1:0] r_cnt;
  logic          r_flush_req;
  logic          r_int_action;
  logic          r_ret_action;
  logic          r_hw_int;
  logic [4:0]    r_int_code;
  logic [31:0]   r_trap_pc;
  logic          r_redirect_valid;
  logic [31:0]   r_redirect_pc;
  logic          r_drain_timeout;

  logic [31:0]   w_pend;
  logic          w_any;
  logic          w_irq_pend;
  logic [4:0]    w_irq_code;
  logic [31:0]   w_base;
  logic          w_vectored;
  logic [31:0]   w_target;
  logic          w_unused_pend;

  assign w_pend        = mip & mie;
  assign w_unused_pend = ^{w_pend[31:12], w_pend[10:8], w_pend[6:4], w_pend[2:0]};
  assign w_any         = w_pend[11] | w_pend[3] | w_pend[7];
  assign w_irq_pend    = mie_global & w_any;

  // Fixed priority: external > software > timer.
  always_comb begin
    w_irq_code = 5'd0;
    if (w_pend[11])     w_irq_code = 5'd11;
    else if (w_pend[3]) w_irq_code = 5'd3;
    else if (w_pend[7]) w_irq_code = 5'd7;
  end

  assign w_base     = {mtvec[31:2], 2'b00};
  assign w_vectored = VECTORED_EN && (mtvec[1:0] == 2'b01);
  assign w_target   = w_vectored ? (w_base + {25'd0, r_int_code, 2'b00}) : w_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_kind           <= K_TRAP;
      r_cnt            <= '0;
      r_flush_req      <= 1'b0;
      r_int_action     <= 1'b0;
      r_ret_action     <= 1'b0;
      r_hw_int         <= 1'b0;
      r_int_code       <= 5'd0;
      r_trap_pc        <= 32'd0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_drain_timeout  <= 1'b0;
    end else begin
      r_int_action <= 1'b0;
      r_ret_action <= 1'b0;
      r_hw_int     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_irq_pend) begin
            r_int_code  <= w_irq_code;
            r_kind      <= K_TRAP;
            r_flush_req <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_FLUSH;
          end else if (mret_req) begin
            r_kind      <= K_RET;
            r_flush_req <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // The timeout only flags a stuck drain; the sequence keeps waiting.
          if (r_cnt != TO_VAL) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt + 1'b1 == TO_VAL) r_drain_timeout <= 1'b1;
          end
          if (pipe_drained) begin
            r_trap_pc <= resume_pc;
            if (r_kind == K_TRAP) begin
              r_int_action <= 1'b1;
              r_hw_int     <= 1'b1;
              r_state      <= S_TAKE;
            end else begin
              r_ret_action <= 1'b1;
              r_state      <= S_RET;
            end
          end
        end
        S_TAKE: begin
          r_redirect_pc    <= w_target;
          r_redirect_valid <= 1'b1;
          r_state          <= S_REDIR;
        end
        S_RET: begin
          r_redirect_pc    <= mepc;
          r_redirect_valid <= 1'b1;
          r_state          <= S_REDIR;
        end
        S_REDIR: begin
          if (redirect_ack) begin
            r_redirect_valid <= 1'b0;
            r_flush_req      <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_flush_req      <= 1'b0;
          r_state          <= S_IDLE;
        end
      endcase
    end
  end

  // mret_done must land in the ack cycle so the core can drop mret_req
  // before the FSM samples it again in IDLE.
  assign mret_done      = (r_state == S_REDIR) && redirect_ack && (r_kind == K_RET);
  assign busy           = (r_state != S_IDLE);
  assign flush_req      = r_flush_req;
  assign int_action     = r_int_action;
  assign ret_action     = r_ret_action;
  assign hw_int         = r_hw_int;
  assign int_code       = r_int_code;
  assign trap_pc        = r_trap_pc;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign drain_timeout  = r_drain_timeout;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed trap/mret sequences, expected
// events queued by the stimulus and consumed by an independent monitor.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mip, mie, mtvec, mepc, resume_pc;
  logic        mie_global, mret_req, pipe_drained, redirect_ack;
  logic        flush_req, int_action, ret_action, hw_int;
  logic [4:0]  int_code;
  logic [31:0] trap_pc, redirect_pc;
  logic        redirect_valid, mret_done, busy, drain_timeout;

  int checks   = 0;
  int failures = 0;

  localparam int EV_INT = 0, EV_RET = 1, EV_REDIR = 2;
  typedef struct {
    int          typ;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        done;
  } exp_t;
  exp_t exp_q[$];

  trap_sequencer #(.DRAIN_TIMEOUT(4), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .mip(mip), .mie(mie), .mie_global(mie_global),
    .mtvec(mtvec), .mepc(mepc), .mret_req(mret_req), .pipe_drained(pipe_drained),
    .resume_pc(resume_pc), .redirect_ack(redirect_ack), .flush_req(flush_req),
    .int_action(int_action), .ret_action(ret_action), .hw_int(hw_int),
    .int_code(int_code), .trap_pc(trap_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mret_done(mret_done), .busy(busy),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic push(input int typ, input logic [4:0] code, input logic [31:0] pc,
                      input logic done);
    exp_t e;
    e.typ = typ; e.code = code; e.pc = pc; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int typ);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event actual_type=%0d required=none", typ);
    end else begin
      e = exp_q.pop_front();
      chk("event_type", typ, e.typ);
      if (e.typ == typ) begin
        if (typ == EV_INT) begin
          chk("int_code", {27'd0, int_code}, {27'd0, e.code});
          chk("hw_int", {31'd0, hw_int}, 32'd1);
          chk("trap_pc", trap_pc, e.pc);
        end else if (typ == EV_RET) begin
          chk("ret_trap_pc", trap_pc, e.pc);
          chk("ret_hw_int", {31'd0, hw_int}, 32'd0);
        end else begin
          chk("redirect_pc", redirect_pc, e.pc);
          chk("mret_done", {31'd0, mret_done}, {31'd0, e.done});
        end
      end
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (reset_n) begin
      if (int_action && ret_action) begin
        checks++; failures++;
        $display("FAIL both_actions actual=1 required=0");
      end
      if (int_action) pop_chk(EV_INT);
      if (ret_action) pop_chk(EV_RET);
      if (redirect_valid && redirect_ack) pop_chk(EV_REDIR);
      if (mret_done && !(redirect_valid && redirect_ack)) begin
        checks++; failures++;
        $display("FAIL stray_mret_done actual=1 required=0");
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_redir(output int n);
    n = 0;
    while (!redirect_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!redirect_valid) begin
      checks++; failures++;
      $display("FAIL redirect_timeout actual=0 required=1");
    end
  endtask

  task automatic ack(input bit clr_mie, input bit drop_mret);
    redirect_ack = 1'b1;
    if (clr_mie) mie_global = 1'b0;
    @(posedge clk); #1;
    redirect_ack = 1'b0;
    if (drop_mret) mret_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {21'd0, flush_req, int_action, ret_action, hw_int,
        redirect_valid, mret_done, busy, drain_timeout, 3'd0},
        32'd0);
    chk({tag, "_int_code"}, {27'd0, int_code}, 32'd0);
    chk({tag, "_trap_pc"}, trap_pc, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; mip = 0; mie = 0; mie_global = 0; mtvec = 0; mepc = 0;
    resume_pc = 0; mret_req = 0; pipe_drained = 1'b1; redirect_ack = 0;
    cyc(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    cyc(2);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Direct-mode timer trap, minimum latency, redirect held until ack.
    mtvec = 32'h0000_1000; mie = 32'h80; mip = 32'h80; mie_global = 1'b1;
    resume_pc = 32'h200;
    push(EV_INT, 5'd7, 32'h200, 1'b0);
    push(EV_REDIR, 5'd0, 32'h1000, 1'b0);
    wait_redir(n);
    chk("latency", n, 3);
    chk("busy_redir", {31'd0, busy}, 32'd1);
    cyc(2);
    chk("redir_hold_valid", {31'd0, redirect_valid}, 32'd1);
    chk("redir_hold_pc", redirect_pc, 32'h1000);
    chk("flush_in_redir", {31'd0, flush_req}, 32'd1);
    ack(1'b1, 1'b0);
    mip = 0;
    chk("valid_drop", {31'd0, redirect_valid}, 32'd0);
    chk("flush_drop", {31'd0, flush_req}, 32'd0);
    cyc(2);

    // Vectored priority, mret, then the next-priority source.
    mtvec = 32'h0000_1001; mip = 32'h888; mie = 32'h888; mie_global = 1'b1;
    push(EV_INT, 5'd11, 32'h200, 1'b0);
    push(EV_REDIR, 5'd0, 32'h102C, 1'b0);
    wait_redir(n);
    ack(1'b1, 1'b0);
    mip = 32'h088; mepc = 32'h500; mret_req = 1'b1;
    push(EV_RET, 5'd0, 32'h200, 1'b0);
    push(EV_REDIR, 5'd0, 32'h500, 1'b1);
    wait_redir(n);
    ack(1'b0, 1'b1);
    mie_global = 1'b1;
    push(EV_INT, 5'd3, 32'h200, 1'b0);
    push(EV_REDIR, 5'd0, 32'h100C, 1'b0);
    wait_redir(n);
    ack(1'b1, 1'b0);
    mip = 0;
    cyc(2);

    // Plain mret; mepc changing after RET must not disturb redirect_pc.
    mepc = 32'h340; resume_pc = 32'h3A0; mret_req = 1'b1;
    push(EV_RET, 5'd0, 32'h3A0, 1'b0);
    push(EV_REDIR, 5'd0, 32'h340, 1'b1);
    wait_redir(n);
    mepc = 32'h999;
    cyc(1);
    chk("mret_pc_stable", redirect_pc, 32'h340);
    ack(1'b0, 1'b1);
    cyc(2);

    // Interrupt and mret together: trap first, then the held mret.
    mtvec = 32'h0000_1000; mepc = 32'h340; resume_pc = 32'h240;
    mip = 32'h80; mie = 32'h80; mie_global = 1'b1; mret_req = 1'b1;
    push(EV_INT, 5'd7, 32'h240, 1'b0);
    push(EV_REDIR, 5'd0, 32'h1000, 1'b0);
    push(EV_RET, 5'd0, 32'h240, 1'b0);
    push(EV_REDIR, 5'd0, 32'h340, 1'b1);
    wait_redir(n);
    ack(1'b1, 1'b0);
    wait_redir(n);
    ack(1'b0, 1'b1);
    mip = 0;
    cyc(2);

    // Drain stall past the timeout, with mip withdrawn during FLUSH.
    chk("timeout_clear", {31'd0, drain_timeout}, 32'd0);
    pipe_drained = 1'b0; resume_pc = 32'h480;
    mip = 32'h80; mie_global = 1'b1;
    push(EV_INT, 5'd7, 32'h480, 1'b0);
    push(EV_REDIR, 5'd0, 32'h1000, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 2) begin
        mip = 0; mie_global = 1'b0;
      end
      if (i == 4) chk("timeout_early", {31'd0, drain_timeout}, 32'd0);
      if (i == 5) chk("timeout_set", {31'd0, drain_timeout}, 32'd1);
    end
    chk("stall_flush", {31'd0, flush_req}, 32'd1);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    pipe_drained = 1'b1;
    wait_redir(n);
    ack(1'b0, 1'b0);
    chk("timeout_sticky", {31'd0, drain_timeout}, 32'd1);
    cyc(2);

    // Asynchronous reset while in REDIR.
    mip = 32'h80; mie_global = 1'b1; resume_pc = 32'h600;
    push(EV_INT, 5'd7, 32'h600, 1'b0);
    wait_redir(n);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    mip = 0; mie_global = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(3);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences machine-mode interrupt entry and mret return around csr_reg and the core pipeline.
- Selects the highest-priority enabled pending interrupt from mip/mie gated by the global MIE bit.
- Drains the pipeline through a flush handshake, then pulses int_action/ret_action into csr_reg with hw_int, int_code and the resume PC.
- Issues the PC redirect to the handler (direct or vectored mtvec) or to mepc.

Parameters:
DRAIN_TIMEOUT, 64, maximum cycles in FLUSH before drain_timeout is set (counter width = clog2(DRAIN_TIMEOUT)+1)
VECTORED_EN, 1, 1 = honour mtvec[1:0]==2'b01 vectored mode; 0 = always direct

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
mip  input  32  pending bits from csr_reg
mie  input  32  enable bits from csr_reg
mie_global  input  1  mstatus.MIE from csr_reg
mtvec  input  32  trap vector base/mode from csr_reg
mepc  input  32  return PC from csr_reg
mret_req  input  1  decoded mret; level, held until mret_done
pipe_drained  input  1  pipeline empty, resume_pc valid
resume_pc  input  32  PC of oldest uncommitted instruction
redirect_ack  input  1  fetch accepted redirect_pc
flush_req  output  1  request pipeline drain/stall
int_action  output  1  1-cycle pulse to csr_reg trap entry
ret_action  output  1  1-cycle pulse to csr_reg mret
hw_int  output  1  interrupt flag to mcause[31]
int_code  output  5  cause code to csr_reg
trap_pc  output  32  PC saved into mepc (csr_reg current_pc)
redirect_valid  output  1  redirect request
redirect_pc  output  32  redirect target
mret_done  output  1  1-cycle pulse, mret completed
busy  output  1  FSM not in IDLE
drain_timeout  output  1  sticky, FLUSH exceeded DRAIN_TIMEOUT

Behaviour:
- Reset: state IDLE. All outputs 0; int_code 0, trap_pc 0, redirect_pc 0; drain_timeout cleared.
- Priority, combinational on (mip & mie), qualified by mie_global:
  - bit 11 (MEI, code 11) > bit 3 (MSI, code 3) > bit 7 (MTI, code 7).
  - Other bits are ignored.
  - irq_pend = mie_global & any selected.
- States: IDLE, FLUSH, TAKE, RET, REDIR.
- IDLE:
  - irq_pend: latch code into int_code, set latched kind=TRAP, go FLUSH.
  - Else mret_req: latch kind=RET, go FLUSH.
  - Interrupt wins when both are present; mret stays held and is served afterwards.
- FLUSH:
  - flush_req=1.
  - Counter increments each cycle; on reaching DRAIN_TIMEOUT, drain_timeout is set and sticky until reset. FSM keeps waiting.
  - On pipe_drained: trap_pc <= resume_pc; go TAKE (TRAP) or RET (RET).
  - The latched code is committed: deassertion of mip/mie/mie_global during FLUSH does not abort.
- TAKE, one cycle:
  - int_action=1, hw_int=1, int_code held, trap_pc held, flush_req=1.
  - redirect_pc <= target. Target = {mtvec[31:2],2'b00} + (int_code<<2) if VECTORED_EN and mtvec[1:0]==2'b01, else {mtvec[31:2],2'b00}. 32-bit modulo add.
  - Go REDIR.
- RET, one cycle:
  - ret_action=1, flush_req=1, redirect_pc <= mepc; go REDIR.
  - mepc is sampled here, before any later CSR write.
- REDIR:
  - redirect_valid=1, flush_req=1; redirect_pc stable while valid.
  - On redirect_ack: redirect_valid drops next cycle, flush_req drops, go IDLE.
  - mret_done pulses on the ack cycle if kind=RET.
- int_action and ret_action are never both high. Each pulses exactly once per sequence.
- An interrupt arriving in any non-IDLE state is evaluated only on return to IDLE. After TAKE, csr_reg clears MIE, so no re-entry until mret.
- Minimum latency, event to redirect_valid, with pipe_drained already high: IDLE → FLUSH → TAKE/RET → REDIR = redirect_valid in cycle 4.
- reset_n low mid-sequence: immediate return to IDLE and all outputs 0, regardless of state. No pulse is emitted.
- busy = (state != IDLE).

Test Plan:
- Direct trap: mtvec=0x0000_1000, mie[7]=1, mip[7]=1, mie_global=1, pipe_drained=1, resume_pc=0x200 → one int_action pulse with int_code=7, hw_int=1, trap_pc=0x200; redirect_pc=0x1000 until redirect_ack.
- Vectored priority: mtvec=0x0000_1001, mip=mie=0x888 → int_code=11, redirect_pc=0x102C; after mret and return to IDLE with MIE=1 and mip=0x088, next trap has code 3, redirect_pc=0x100C.
- mret: mepc=0x0000_0340, mret_req=1 → ret_action pulse once, redirect_pc=0x340, mret_done pulse on the redirect_ack cycle; int_action stays 0.
- Simultaneous events: mret_req=1 and MTI pending in IDLE → trap serviced first; mret_req still held, so the RET sequence follows and ret_action occurs after the trap's redirect_ack.
- Drain stall with DRAIN_TIMEOUT=4: pipe_drained=0 for 10 cycles → drain_timeout=1 after 4 FLUSH cycles and stays set; raising pipe_drained completes the trap normally.
- Reset and withdrawal:
  - reset_n low during REDIR → all outputs 0 immediately, state IDLE.
  - mip dropped during FLUSH → trap still completes with the latched code.
